pipeline_stall_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline.
//  - Merges the load-use stall from the hazard detection unit and the ID-stage branch flush.
//  - Adds a req/ack handshake to a multi-cycle data memory, freezing the pipeline until each access completes.
//  - Drives every pipeline-register write enable, flush and bubble.
//  - Keeps a saturating stall-cycle counter and a sticky memory-timeout error.

---
 rtl/pipeline_stall_controller.sv | 74 +++++++
 tb/tb_pipeline_stall_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: stall/flush sequencer merging load-use stalls, branch flushes and a req/ack data-memory handshake
module pipeline_stall_controller #(
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 hazard_stall_i,
    input  logic                 branch_taken_i,
    input  logic                 EXMEM_MemRead_i,
    input  logic                 EXMEM_MemWrite_i,
    input  logic                 mem_ack_i,
    output logic                 mem_req_o,
    output logic                 PC_write_o,
    output logic                 IFID_write_o,
    output logic                 IFID_flush_o,
    output logic                 IDEX_bubble_o,
    output logic                 EXMEM_write_o,
    output logic                 MEMWB_bubble_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DONE, S_ERR} state_t;
    state_t                 state_q;
    logic                   mem_req_q, error_q;
    logic [15:0]            wait_q;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   mem_acc, freeze, go;
    always_comb begin
        mem_acc        = EXMEM_MemRead_i | EXMEM_MemWrite_i;
        freeze         = (state_q == S_RUN && mem_acc) || state_q == S_WAIT || state_q == S_ERR;
        go             = ~rst_i & ~freeze & ~hazard_stall_i;
        PC_write_o     = go;
        IFID_write_o   = go;
        IFID_flush_o   = go & branch_taken_i;
        IDEX_bubble_o  = ~rst_i & ~freeze & hazard_stall_i;
        EXMEM_write_o  = ~rst_i & ~freeze;
        MEMWB_bubble_o = ~rst_i & freeze;
        cnt_d          = ((freeze | hazard_stall_i) && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_RUN;
            mem_req_q <= 1'b0;
            error_q   <= 1'b0;
            wait_q    <= '0;
            cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                S_RUN: if (mem_acc) begin
                    state_q   <= S_WAIT;
                    mem_req_q <= 1'b1;
                    wait_q    <= '0;
                end
                S_WAIT: if (mem_ack_i) begin
                    state_q   <= S_DONE;
                    mem_req_q <= 1'b0;
                end else if (wait_q == 16'(TIMEOUT - 1)) begin
                    state_q   <= S_ERR;
                    mem_req_q <= 1'b0;
                    error_q   <= 1'b1;
                end else begin
                    wait_q <= wait_q + 16'd1;
                end
                S_DONE: state_q <= S_RUN;
                default: state_q <= S_ERR;
            endcase
        end
    end
    assign mem_req_o   = mem_req_q;
    assign error_o     = error_q;
    assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed vector table, corner sequences and random run against a behavioural model
module tb_pipeline_stall_controller;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst, hz, br, rd, wr, ack;
    logic req, pcw, ifw, fl, idb, exw, mwb, err;
    logic [CW-1:0] cnt;
    typedef struct {
        logic [5:0] in;
        logic [7:0] exp;
        int         c;
    } vec_t;
    vec_t tab[$];
    int n_vec = 0, n_fail = 0;
    bit m_busy, m_done, m_err, m_req;
    int m_w, m_cnt;

    pipeline_stall_controller #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .hazard_stall_i(hz), .branch_taken_i(br),
        .EXMEM_MemRead_i(rd), .EXMEM_MemWrite_i(wr), .mem_ack_i(ack),
        .mem_req_o(req), .PC_write_o(pcw), .IFID_write_o(ifw), .IFID_flush_o(fl),
        .IDEX_bubble_o(idb), .EXMEM_write_o(exw), .MEMWB_bubble_o(mwb),
        .error_o(err), .stall_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [5:0] i, logic [7:0] e, int c);
        vec_t v;
        v.in = i; v.exp = e; v.c = c;
        return v;
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(logic [5:0] v);
        @(negedge clk);
        {rst, hz, br, rd, wr, ack} = v;
        #1;
    endtask

    function automatic bit m_freeze();
        return m_err || m_busy || (!m_done && !m_busy && (rd || wr));
    endfunction

    task automatic check_model(string tag);
        bit fz, live;
        fz = m_freeze();
        live = !rst;
        cmp({tag, " PC_write"},    32'(pcw), 32'(live && !fz && !hz));
        cmp({tag, " IFID_write"},  32'(ifw), 32'(live && !fz && !hz));
        cmp({tag, " IFID_flush"},  32'(fl),  32'(live && !fz && !hz && br));
        cmp({tag, " IDEX_bubble"}, 32'(idb), 32'(live && !fz && hz));
        cmp({tag, " EXMEM_write"}, 32'(exw), 32'(live && !fz));
        cmp({tag, " MEMWB_bubble"},32'(mwb), 32'(live && fz));
        cmp({tag, " mem_req"},     32'(req), 32'(m_req));
        cmp({tag, " error"},       32'(err), 32'(m_err));
        cmp({tag, " stall_cnt"},   32'(cnt), 32'(m_cnt));
    endtask

    task automatic adv();
        bit fz;
        fz = m_freeze();
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_req = 0; m_w = 0; m_cnt = 0;
        end else begin
            if ((fz || hz) && m_cnt < CMAX) m_cnt++;
            if (m_err) begin
            end else if (m_busy) begin
                if (ack) begin m_busy = 0; m_done = 1; m_req = 0; end
                else if (m_w == TO - 1) begin m_busy = 0; m_err = 1; m_req = 0; end
                else m_w++;
            end else if (m_done) m_done = 0;
            else if (rd || wr) begin m_busy = 1; m_w = 0; m_req = 1; end
        end
    endtask

    initial begin
        // {rst,hz,br,rd,wr,ack} -> {pc,ifw,flush,idex_b,exmem_w,memwb_b,req,err}, stall_cnt
        tab.push_back(mk(6'b100000, 8'b00000000, 0));
        tab.push_back(mk(6'b000000, 8'b11001000, 0));
        tab.push_back(mk(6'b001000, 8'b11101000, 0));
        tab.push_back(mk(6'b011000, 8'b00011000, 0));
        tab.push_back(mk(6'b001000, 8'b11101000, 1));
        tab.push_back(mk(6'b000100, 8'b00000100, 1));
        tab.push_back(mk(6'b000100, 8'b00000110, 2));
        tab.push_back(mk(6'b011100, 8'b00000110, 3));
        tab.push_back(mk(6'b000101, 8'b00000110, 4));
        tab.push_back(mk(6'b001100, 8'b11101000, 5));
        tab.push_back(mk(6'b000010, 8'b00000100, 5));
        tab.push_back(mk(6'b000011, 8'b00000110, 6));
        tab.push_back(mk(6'b000100, 8'b11001000, 7));
        tab.push_back(mk(6'b000100, 8'b00000100, 7));
        tab.push_back(mk(6'b000101, 8'b00000110, 8));
        tab.push_back(mk(6'b000000, 8'b11001000, 9));
        tab.push_back(mk(6'b000001, 8'b11001000, 9));
        tab.push_back(mk(6'b000100, 8'b00000100, 9));
        tab.push_back(mk(6'b000100, 8'b00000110, 10));
        tab.push_back(mk(6'b000100, 8'b00000110, 11));
        tab.push_back(mk(6'b000100, 8'b00000110, 12));
        tab.push_back(mk(6'b000100, 8'b00000110, 13));
        tab.push_back(mk(6'b000001, 8'b00000101, 14));
        tab.push_back(mk(6'b010000, 8'b00000101, 15));
        tab.push_back(mk(6'b000000, 8'b00000101, 15));
        tab.push_back(mk(6'b100000, 8'b00000001, 15));
        tab.push_back(mk(6'b000000, 8'b11001000, 0));
        tab.push_back(mk(6'b000100, 8'b00000100, 0));
        tab.push_back(mk(6'b000100, 8'b00000110, 1));
        tab.push_back(mk(6'b000100, 8'b00000110, 2));
        tab.push_back(mk(6'b000100, 8'b00000110, 3));
        tab.push_back(mk(6'b000101, 8'b00000110, 4));
        tab.push_back(mk(6'b000000, 8'b11001000, 5));
        tab.push_back(mk(6'b000100, 8'b00000100, 5));
        tab.push_back(mk(6'b100100, 8'b00000010, 6));
        tab.push_back(mk(6'b000001, 8'b11001000, 0));

        {rst, hz, br, rd, wr, ack} = 6'b100000;
        m_busy = 0; m_done = 0; m_err = 0; m_req = 0; m_w = 0; m_cnt = 0;
        repeat (2) @(posedge clk);

        foreach (tab[i]) begin
            drive(tab[i].in);
            cmp($sformatf("tab[%0d] outs", i), 32'({pcw, ifw, fl, idb, exw, mwb, req, err}), 32'(tab[i].exp));
            cmp($sformatf("tab[%0d] stall_cnt", i), 32'(cnt), 32'(tab[i].c));
            adv();
        end

        for (int i = 0; i < 20; i++) begin
            drive(6'b010000);
            adv();
        end
        drive(6'b000000);
        cmp("saturate stall_cnt", 32'(cnt), 32'(CMAX));
        check_model("sat");
        adv();

        for (int i = 0; i < 800; i++) begin
            drive({6'($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 2) == 0)});
            check_model($sformatf("rnd[%0d]", i));
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
